// File: rtl/vec_mem_rd_port.sv
`default_nettype none
// ============================================================================
// vec_mem_rd_port : vector LSU read port -- credit-limited req/gnt issue to
//                   memory, in-order response FIFO, flush with drain.
// Rev 1.0
// ============================================================================
module vec_mem_rd_port #(
  parameter int XLEN       = 32,
  parameter int SEW        = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            lsu_req_valid,
  input  logic [XLEN-1:0] lsu_req_addr,
  output logic            lsu_req_ready,
  output logic            mem_req,
  output logic [XLEN-1:0] mem_addr,
  input  logic            mem_gnt,
  input  logic            mem_rvalid,
  input  logic [SEW-1:0]  mem_rdata,
  output logic            lsu_rsp_valid,
  output logic [SEW-1:0]  lsu_rsp_data,
  input  logic            lsu_rsp_ready,
  input  logic            flush,
  output logic            busy,
  output logic            err_unexp
);
  localparam int c_PW = $clog2(FIFO_DEPTH);
  localparam int c_CW = c_PW + 1;
  localparam logic [c_CW:0] c_DEPTH_W = (c_CW+1)'(FIFO_DEPTH);
  localparam logic [c_CW-1:0] c_DEPTH = c_CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE = 2'd0, ACTIVE = 2'd1, DRAIN = 2'd2} state_t;

  state_t            r_state;
  logic              r_mem_req;
  logic [XLEN-1:0]   r_mem_addr;
  logic [c_CW-1:0]   r_outst;
  logic [c_CW-1:0]   r_drop_cnt;
  logic [c_CW-1:0]   r_fifo_cnt;
  logic [c_PW-1:0]   r_wptr;
  logic [c_PW-1:0]   r_rptr;
  logic [SEW-1:0]    r_fifo [FIFO_DEPTH];
  logic              r_err;

  logic              w_gnt;
  logic              w_accept;
  logic              w_rv_ok;
  logic              w_rv_drop;
  logic              w_push;
  logic              w_pop;
  logic              w_credit_ok;
  logic [c_CW:0]     w_inflight;
  logic [c_CW-1:0]   w_outst_nxt;

  // The held request is counted even when granted this cycle: it still
  // becomes a FIFO entry, so every accepted address owns one slot.
  assign w_inflight  = (c_CW+1)'(r_mem_req) + {1'b0, r_outst} + {1'b0, r_fifo_cnt};
  assign w_credit_ok = w_inflight < c_DEPTH_W;

  assign w_gnt         = r_mem_req & mem_gnt;
  assign lsu_req_ready = !rst && !flush && (r_state != DRAIN)
                         && (!r_mem_req || mem_gnt) && w_credit_ok;
  assign w_accept      = lsu_req_valid & lsu_req_ready;
  assign w_rv_ok       = mem_rvalid && (r_outst != '0);
  assign w_rv_drop     = w_rv_ok && (r_drop_cnt != '0);
  assign w_push        = w_rv_ok && (r_drop_cnt == '0) && !flush;
  assign w_pop         = lsu_rsp_valid && lsu_rsp_ready && !flush;
  assign w_outst_nxt   = r_outst + c_CW'(w_gnt) - c_CW'(w_rv_ok);

  assign mem_req       = r_mem_req;
  assign mem_addr      = r_mem_addr;
  assign lsu_rsp_valid = (r_fifo_cnt != '0);
  assign lsu_rsp_data  = r_fifo[r_rptr];
  assign busy          = (r_state != IDLE);
  assign err_unexp     = r_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else if (flush) begin
      r_state <= (w_outst_nxt != '0) ? DRAIN : IDLE;
    end else begin
      case (r_state)
        IDLE:    if (w_accept) r_state <= ACTIVE;
        ACTIVE:  if (!r_mem_req && r_outst == '0 && r_fifo_cnt == '0 && !w_accept)
                   r_state <= IDLE;
        DRAIN:   if (r_drop_cnt == '0) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mem_req  <= 1'b0;
      r_mem_addr <= '0;
      r_outst    <= '0;
      r_drop_cnt <= '0;
      r_fifo_cnt <= '0;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_err      <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) r_fifo[i] <= '0;
    end else begin
      if (flush) begin
        r_mem_req <= 1'b0;
      end else if (w_accept) begin
        r_mem_req  <= 1'b1;
        r_mem_addr <= lsu_req_addr;
      end else if (w_gnt) begin
        r_mem_req <= 1'b0;
      end

      r_outst <= w_outst_nxt;

      if (flush)          r_drop_cnt <= w_outst_nxt;
      else if (w_rv_drop) r_drop_cnt <= r_drop_cnt - 1'b1;

      if (mem_rvalid && r_outst == '0) r_err <= 1'b1;

      if (flush) begin
        r_fifo_cnt <= '0;
        r_wptr     <= '0;
        r_rptr     <= '0;
      end else begin
        if (w_push) begin
          r_fifo[r_wptr] <= mem_rdata;
          r_wptr         <= r_wptr + 1'b1;
        end
        if (w_pop) r_rptr <= r_rptr + 1'b1;
        r_fifo_cnt <= r_fifo_cnt + c_CW'(w_push) - c_CW'(w_pop);
      end
    end
  end

  a_no_push_full: assert property (@(posedge clk) disable iff (rst)
                                   !(w_push && r_fifo_cnt == c_DEPTH));

endmodule
`default_nettype wire
